// File: rtl/alu_result_stage.sv
// alu_result_stage: registers the ALU 4:1 mux result with its encoded unit index,
// buffers up to two results behind valid/ready, and tracks illegal (non-one-hot) selects.
module alu_result_stage #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [3:0]            IN_SEL,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [1:0]            OUT_UNIT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    input  logic                  ERR_CLR,
    output logic                  SEL_ERR,
    output logic [CNT_WIDTH-1:0]  ERR_CNT
);

    localparam int unsigned DEPTH = 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            unit;
    } entry_t;

    entry_t     mem [DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ;

    logic       sel_legal;
    logic [1:0] sel_unit;
    logic       accept;
    logic       push;
    logic       pop;
    logic       bad_accept;

    // Handshake flags derive only from registered occupancy, so no input-to-ready path exists.
    assign IN_READY  = (occ < 2'(DEPTH));
    assign OUT_VALID = (occ != 2'd0);
    assign OUT_DATA  = OUT_VALID ? mem[rd_ptr].data : '0;
    assign OUT_UNIT  = OUT_VALID ? mem[rd_ptr].unit : 2'd0;

    // One-hot select to unit index; anything else is flagged illegal.
    always_comb begin
        sel_legal = 1'b1;
        sel_unit  = 2'd0;
        case (IN_SEL)
            4'b1000: sel_unit = 2'd0;
            4'b0100: sel_unit = 2'd1;
            4'b0010: sel_unit = 2'd2;
            4'b0001: sel_unit = 2'd3;
            default: sel_legal = 1'b0;
        endcase
    end

    assign accept     = IN_VALID && IN_READY;
    assign push       = accept && sel_legal;
    assign bad_accept = accept && !sel_legal;
    assign pop        = OUT_VALID && OUT_READY;

    // Buffer storage; contents are masked by OUT_VALID so they need no reset.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= '{data: IN_DATA, unit: sel_unit};
        end
    end

    // Pointers and occupancy; a push and pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

    // Sticky error flag and saturating counter; an illegal accept overrides a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SEL_ERR <= 1'b0;
            ERR_CNT <= '0;
        end else if (bad_accept) begin
            SEL_ERR <= 1'b1;
            if (ERR_CLR) begin
                ERR_CNT <= CNT_WIDTH'(1);
            end else if (ERR_CNT != CNT_MAX) begin
                ERR_CNT <= ERR_CNT + CNT_WIDTH'(1);
            end
        end else if (ERR_CLR) begin
            SEL_ERR <= 1'b0;
            ERR_CNT <= '0;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench for alu_result_stage.
module tb_alu_result_stage;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = 15;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] IN_DATA;
    logic [3:0]    IN_SEL;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] OUT_DATA;
    logic [1:0]    OUT_UNIT;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic          ERR_CLR;
    logic          SEL_ERR;
    logic [CW-1:0] ERR_CNT;

    alu_result_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST),
        .IN_DATA(IN_DATA), .IN_SEL(IN_SEL), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_UNIT(OUT_UNIT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .ERR_CLR(ERR_CLR), .SEL_ERR(SEL_ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [DW+1:0] sb[$];   // {data, unit}
    logic          m_err;
    int            m_cnt;
    logic          last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] decode(input logic [3:0] s);
        // {legal, unit}
        case (s)
            4'b1000: return 3'b100;
            4'b0100: return 3'b101;
            4'b0010: return 3'b110;
            4'b0001: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Compare outputs against the model, advance the model, then advance one clock.
    task automatic step();
        logic       acc;
        logic       pp;
        logic [2:0] d;
        chk("in_ready", 32'(IN_READY), 32'(sb.size() < 2));
        chk("out_valid", 32'(OUT_VALID), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("out_data", 32'(OUT_DATA), 32'(sb[0][DW+1:2]));
            chk("out_unit", 32'(OUT_UNIT), 32'(sb[0][1:0]));
        end else begin
            chk("out_data_idle", 32'(OUT_DATA), 32'h0);
            chk("out_unit_idle", 32'(OUT_UNIT), 32'h0);
        end
        chk("sel_err", 32'(SEL_ERR), 32'(m_err));
        chk("err_cnt", 32'(ERR_CNT), 32'(m_cnt));

        acc = IN_VALID && (sb.size() < 2);
        pp  = OUT_READY && (sb.size() != 0);
        d   = decode(IN_SEL);
        last_acc = acc;
        if (RST) begin
            sb.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            if (pp) void'(sb.pop_front());
            if (acc && d[2]) sb.push_back({IN_DATA, d[1:0]});
            if (acc && !d[2]) begin
                m_err = 1'b1;
                if (ERR_CLR) m_cnt = 1;
                else if (m_cnt < CMAX) m_cnt++;
            end else if (ERR_CLR) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Offer one input until accepted, with a bounded wait.
    task automatic send(input logic [DW-1:0] data, input logic [3:0] sel);
        int n;
        IN_DATA  = data;
        IN_SEL   = sel;
        IN_VALID = 1'b1;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 20) begin
            step();
            n++;
        end
        if (!last_acc) chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        int n;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'(0));
        step();
    endtask

    initial begin
        RST = 1'b1; IN_DATA = '0; IN_SEL = 4'b1000; IN_VALID = 1'b1;
        OUT_READY = 1'b0; ERR_CLR = 1'b0;
        m_err = 1'b0; m_cnt = 0; last_acc = 1'b0;
        @(posedge CLK);
        @(negedge CLK);

        // Reset with IN_VALID held high
        step();
        step();
        RST = 1'b0; IN_VALID = 1'b0;
        chk("rst_in_ready", 32'(IN_READY), 32'(1));
        chk("rst_out_valid", 32'(OUT_VALID), 32'(0));
        chk("rst_out_data", 32'(OUT_DATA), 32'(0));
        chk("rst_sel_err", 32'(SEL_ERR), 32'(0));
        chk("rst_err_cnt", 32'(ERR_CNT), 32'(0));
        step();

        // Single pass with one-cycle latency
        OUT_READY = 1'b1;
        send(8'hA5, 4'b0100);
        IN_VALID = 1'b0;
        chk("single_valid", 32'(OUT_VALID), 32'(1));
        chk("single_data", 32'(OUT_DATA), 32'hA5);
        chk("single_unit", 32'(OUT_UNIT), 32'(1));
        step();
        chk("single_gone", 32'(OUT_VALID), 32'(0));
        step();

        // Backpressure and full buffer
        OUT_READY = 1'b0;
        send(8'h11, 4'b1000);
        send(8'h22, 4'b0001);
        IN_VALID = 1'b0;
        chk("full_in_ready", 32'(IN_READY), 32'(0));
        IN_DATA = 8'h33; IN_SEL = 4'b1000; IN_VALID = 1'b1;
        step();
        step();
        chk("full_hold_data", 32'(OUT_DATA), 32'h11);
        OUT_READY = 1'b1;
        send(8'h33, 4'b1000);
        drain();

        // Streaming at occupancy 1: push and pop together every cycle
        OUT_READY = 1'b1;
        for (int i = 1; i <= 10; i++) send(8'(i), 4'b0010);
        drain();

        // Random traffic with mostly legal selects
        for (int i = 0; i < 60; i++) begin
            logic [3:0] s;
            case ($urandom_range(0, 4))
                0: s = 4'b1000;
                1: s = 4'b0100;
                2: s = 4'b0010;
                3: s = 4'b0001;
                default: s = 4'($urandom);
            endcase
            IN_DATA   = 8'($urandom);
            IN_SEL    = s;
            IN_VALID  = 1'($urandom);
            OUT_READY = 1'($urandom);
            step();
        end
        drain();

        // Illegal selects
        ERR_CLR = 1'b1; IN_VALID = 1'b0;
        step();
        ERR_CLR = 1'b0;
        send(8'h55, 4'b0000);
        send(8'h66, 4'b1100);
        IN_VALID = 1'b0;
        chk("illegal_err", 32'(SEL_ERR), 32'(1));
        chk("illegal_cnt", 32'(ERR_CNT), 32'(2));
        chk("illegal_nodata", 32'(OUT_VALID), 32'(0));
        step();
        for (int i = 0; i < 20; i++) send(8'(i), 4'b0011);
        IN_VALID = 1'b0;
        chk("sat_cnt", 32'(ERR_CNT), 32'(CMAX));
        step();
        ERR_CLR = 1'b1;
        send(8'h77, 4'b1111);
        ERR_CLR = 1'b0; IN_VALID = 1'b0;
        chk("clr_win_err", 32'(SEL_ERR), 32'(1));
        chk("clr_win_cnt", 32'(ERR_CNT), 32'(1));
        step();

        // Reset with two buffered entries
        OUT_READY = 1'b0;
        send(8'h81, 4'b0100);
        send(8'h82, 4'b0010);
        IN_VALID = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_mid_valid", 32'(OUT_VALID), 32'(0));
        chk("rst_mid_ready", 32'(IN_READY), 32'(1));
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
